// File: rtl/sc_random_pkg.sv
// Shared state encoding, default parameters and sizing helpers
// for the random-word round-robin arbiter.
package sc_random_pkg;

  localparam int DEF_DATAWIDTH = 8;
  localparam int DEF_NUM_REQ   = 4;
  localparam int DEF_HOLDOFF   = 2;
  localparam int DEF_TIMEOUT   = 255;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    GRANT = 2'b01,
    HOLD  = 2'b10
  } arb_state_t;

  function automatic int cnt_width(
    input int holdoff,
    input int timeout
  );
    int m;
    m = (holdoff > timeout) ? holdoff : timeout;
    return (m > 0) ? $clog2(m + 1) : 1;
  endfunction

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Priority distance of requester j when the search starts at last+1.
  function automatic int rr_dist(
    input int j,
    input int last,
    input int n
  );
    int d;
    d = j - last - 1;
    if (d < 0) d = d + n;
    return d;
  endfunction

endpackage

// File: rtl/sc_rr_picker.sv
// Combinational round-robin picker: one-hot winner of the requests,
// searching from last_winner+1 and wrapping to 0.
module sc_rr_picker
  import sc_random_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int IW      = idx_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [IW-1:0]      i_last,
  output logic [NUM_REQ-1:0] o_grant,
  output logic               o_any
);

  int w_best;
  int w_dist;

  always_comb begin
    w_best  = NUM_REQ;
    w_dist  = 0;
    o_grant = '0;
    for (int j = 0; j < NUM_REQ; j++) begin
      w_dist = rr_dist(j, int'(i_last), NUM_REQ);
      if (i_req[j] && (w_dist < w_best)) w_best = w_dist;
    end
    for (int j = 0; j < NUM_REQ; j++) begin
      w_dist     = rr_dist(j, int'(i_last), NUM_REQ);
      o_grant[j] = i_req[j] && (w_dist == w_best);
    end
    o_any = |i_req;
  end

endmodule

// File: rtl/sc_random_arbiter.sv
// Round-robin arbiter that hands each winner a random word latched
// from an external LFSR, with release holdoff and grant timeout.
module sc_random_arbiter
  import sc_random_pkg::*;
#(
  parameter int DATAWIDTH = DEF_DATAWIDTH,
  parameter int NUM_REQ   = DEF_NUM_REQ,
  parameter int HOLDOFF   = DEF_HOLDOFF,
  parameter int TIMEOUT   = DEF_TIMEOUT
) (
  input  logic                 SC_RANDOM_ARBITER_CLOCK_50,
  input  logic                 SC_RANDOM_ARBITER_RESET_InHigh,
  input  logic [DATAWIDTH-1:0] SC_RANDOM_ARBITER_rand_InBUS,
  input  logic [NUM_REQ-1:0]   SC_RANDOM_ARBITER_req_InBUS,
  output logic [NUM_REQ-1:0]   SC_RANDOM_ARBITER_grant_OutBUS,
  output logic [DATAWIDTH-1:0] SC_RANDOM_ARBITER_data_OutBUS,
  output logic                 SC_RANDOM_ARBITER_valid_Out,
  output logic                 SC_RANDOM_ARBITER_timeout_Out
);

  localparam int CW = cnt_width(HOLDOFF, TIMEOUT);
  localparam int IW = idx_width(NUM_REQ);
  // A zero timeout still grants for one cycle.
  localparam logic [CW-1:0] TO_LOAD =
    (TIMEOUT > 0) ? CW'(TIMEOUT) : CW'(1);
  localparam logic [CW-1:0] HO_LOAD = CW'(HOLDOFF);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  arb_state_t           r_state;
  logic [CW-1:0]        r_cnt;
  logic [IW-1:0]        r_last;
  logic [NUM_REQ-1:0]   r_block;
  logic [NUM_REQ-1:0]   r_grant;
  logic [DATAWIDTH-1:0] r_data;
  logic                 r_valid;
  logic                 r_timeout;

  logic [NUM_REQ-1:0]   w_req_ok;
  logic [NUM_REQ-1:0]   w_pick;
  logic                 w_any;
  logic [IW-1:0]        w_pick_idx;
  logic                 w_win_req;

  assign w_req_ok  = SC_RANDOM_ARBITER_req_InBUS & ~r_block;
  assign w_win_req = |(SC_RANDOM_ARBITER_req_InBUS & r_grant);

  sc_rr_picker #(
    .NUM_REQ (NUM_REQ),
    .IW      (IW)
  ) u_picker (
    .i_req   (w_req_ok),
    .i_last  (r_last),
    .o_grant (w_pick),
    .o_any   (w_any)
  );

  always_comb begin
    w_pick_idx = '0;
    for (int j = 0; j < NUM_REQ; j++) begin
      if (w_pick[j]) w_pick_idx = IW'(j);
    end
  end

  always_ff @(posedge SC_RANDOM_ARBITER_CLOCK_50 or
              posedge SC_RANDOM_ARBITER_RESET_InHigh) begin
    if (SC_RANDOM_ARBITER_RESET_InHigh) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_last    <= IW'(NUM_REQ - 1);
      r_block   <= '0;
      r_grant   <= '0;
      r_data    <= '0;
      r_valid   <= 1'b0;
      r_timeout <= 1'b0;
    end else begin
      r_timeout <= 1'b0;
      // A timed-out requester stays blocked until it drops req.
      r_block   <= r_block & SC_RANDOM_ARBITER_req_InBUS;
      unique case (r_state)
        IDLE: begin
          if (w_any) begin
            r_state <= GRANT;
            r_grant <= w_pick;
            r_valid <= 1'b1;
            r_data  <= SC_RANDOM_ARBITER_rand_InBUS;
            r_cnt   <= TO_LOAD;
            r_last  <= w_pick_idx;
          end
        end
        GRANT: begin
          if (!w_win_req || (r_cnt <= CNT_ONE)) begin
            r_grant <= '0;
            r_valid <= 1'b0;
            if (w_win_req) begin
              r_timeout <= 1'b1;
              r_block   <= (r_block & SC_RANDOM_ARBITER_req_InBUS)
                           | r_grant;
            end
            if (HOLDOFF == 0) begin
              r_state <= IDLE;
              r_cnt   <= '0;
            end else begin
              r_state <= HOLD;
              r_cnt   <= HO_LOAD;
            end
          end else begin
            r_cnt <= r_cnt - CNT_ONE;
          end
        end
        HOLD: begin
          if (r_cnt <= CNT_ONE) begin
            r_state <= IDLE;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt - CNT_ONE;
          end
        end
        default: begin
          r_state <= IDLE;
          r_cnt   <= '0;
          r_grant <= '0;
          r_valid <= 1'b0;
        end
      endcase
    end
  end

  assign SC_RANDOM_ARBITER_grant_OutBUS = r_grant;
  assign SC_RANDOM_ARBITER_data_OutBUS  = r_data;
  assign SC_RANDOM_ARBITER_valid_Out    = r_valid;
  assign SC_RANDOM_ARBITER_timeout_Out  = r_timeout;

endmodule

// File: tb/tb_sc_random_arbiter.sv
// Self-checking bench for sc_random_arbiter: vector table with a
// scoreboard queue, plus a hand sequence for mid-grant reset.
module tb_sc_random_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_a, rst_b;
  logic [3:0] req_a, req_b;
  logic [7:0] rnd_a, rnd_b;
  logic [3:0] gnt_a, gnt_b;
  logic [7:0] dat_a, dat_b;
  logic       vld_a, vld_b;
  logic       to_a, to_b;

  sc_random_arbiter u_dut (
    .SC_RANDOM_ARBITER_CLOCK_50     (clk),
    .SC_RANDOM_ARBITER_RESET_InHigh (rst_a),
    .SC_RANDOM_ARBITER_rand_InBUS   (rnd_a),
    .SC_RANDOM_ARBITER_req_InBUS    (req_a),
    .SC_RANDOM_ARBITER_grant_OutBUS (gnt_a),
    .SC_RANDOM_ARBITER_data_OutBUS  (dat_a),
    .SC_RANDOM_ARBITER_valid_Out    (vld_a),
    .SC_RANDOM_ARBITER_timeout_Out  (to_a)
  );

  sc_random_arbiter #(
    .DATAWIDTH (8),
    .NUM_REQ   (4),
    .HOLDOFF   (0),
    .TIMEOUT   (255)
  ) u_dut0 (
    .SC_RANDOM_ARBITER_CLOCK_50     (clk),
    .SC_RANDOM_ARBITER_RESET_InHigh (rst_b),
    .SC_RANDOM_ARBITER_rand_InBUS   (rnd_b),
    .SC_RANDOM_ARBITER_req_InBUS    (req_b),
    .SC_RANDOM_ARBITER_grant_OutBUS (gnt_b),
    .SC_RANDOM_ARBITER_data_OutBUS  (dat_b),
    .SC_RANDOM_ARBITER_valid_Out    (vld_b),
    .SC_RANDOM_ARBITER_timeout_Out  (to_b)
  );

  typedef struct packed {
    logic [3:0] g;
    logic       v;
    logic [7:0] d;
    logic       t;
  } exp_t;

  typedef struct {
    int         dut;
    logic       rst;
    logic [3:0] req;
    logic [7:0] rnd;
    exp_t       e;
    byte        tag;
  } vec_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  function automatic exp_t mk(
    input logic [3:0] g,
    input logic [7:0] d,
    input logic       t
  );
    exp_t e;
    e.g = g;
    e.v = (g != 4'b0000);
    e.d = d;
    e.t = t;
    return e;
  endfunction

  task automatic add(
    input int         dut,
    input logic       rst,
    input logic [3:0] req,
    input logic [7:0] rnd,
    input exp_t       e,
    input byte        tag
  );
    vec_t v;
    v.dut = dut;
    v.rst = rst;
    v.req = req;
    v.rnd = rnd;
    v.e   = e;
    v.tag = tag;
    vecs.push_back(v);
  endtask

  task automatic chk(
    input byte  tag,
    input int   idx,
    input exp_t act,
    input exp_t exp
  );
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %c[%0d]: got g=%b v=%b d=%h t=%b, want g=%b v=%b d=%h t=%b",
               tag, idx, act.g, act.v, act.d, act.t,
               exp.g, exp.v, exp.d, exp.t);
    end
  endtask

  function automatic exp_t act_a();
    return {gnt_a, vld_a, dat_a, to_a};
  endfunction

  function automatic exp_t act_b();
    return {gnt_b, vld_b, dat_b, to_b};
  endfunction

  task automatic run_table();
    exp_t e;
    exp_t a;
    foreach (vecs[i]) begin
      @(negedge clk);
      if (vecs[i].dut == 0) begin
        rst_a = vecs[i].rst;
        req_a = vecs[i].req;
        rnd_a = vecs[i].rnd;
      end else begin
        rst_b = vecs[i].rst;
        req_b = vecs[i].req;
        rnd_b = vecs[i].rnd;
      end
      sb.push_back(vecs[i].e);
      @(posedge clk);
      #1;
      e = sb.pop_front();
      a = (vecs[i].dut == 0) ? act_a() : act_b();
      chk(vecs[i].tag, i, a, e);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] d0;
    logic [3:0] wb;

    rst_a = 1'b1; req_a = '0; rnd_a = '0;
    rst_b = 1'b1; req_b = '0; rnd_b = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("R", 0, act_a(), mk(4'b0000, 8'h00, 1'b0));
    chk("R", 1, act_b(), mk(4'b0000, 8'h00, 1'b0));

    // A: first grant, stable data, others ignored, holdoff length
    add(0, 0, 4'b0001, 8'h5A, mk(4'b0001, 8'h5A, 0), "A");
    add(0, 0, 4'b0001, 8'h11, mk(4'b0001, 8'h5A, 0), "A");
    add(0, 0, 4'b0111, 8'h22, mk(4'b0001, 8'h5A, 0), "A");
    add(0, 0, 4'b0110, 8'h33, mk(4'b0000, 8'h5A, 0), "A");
    add(0, 0, 4'b1000, 8'h44, mk(4'b0000, 8'h5A, 0), "A");
    add(0, 0, 4'b1000, 8'h55, mk(4'b0000, 8'h5A, 0), "A");
    add(0, 0, 4'b1000, 8'h66, mk(4'b1000, 8'h66, 0), "A");
    add(0, 0, 4'b0000, 8'h67, mk(4'b0000, 8'h66, 0), "A");
    add(0, 0, 4'b0000, 8'h68, mk(4'b0000, 8'h66, 0), "A");
    add(0, 0, 4'b0000, 8'h69, mk(4'b0000, 8'h66, 0), "A");

    // B: all requesting, 3 grant cycles each, 2 HOLD + 1 IDLE gap
    add(0, 1, 4'b0000, 8'h00, mk(4'b0000, 8'h00, 0), "B");
    for (int g = 0; g < 5; g++) begin
      d0 = {4'(g + 1), 4'h0};
      wb = 4'(1 << (g % 4));
      add(0, 0, 4'b1111, d0,        mk(wb, d0, 0), "B");
      add(0, 0, 4'b1111, d0 + 8'd1, mk(wb, d0, 0), "B");
      add(0, 0, 4'b1111, d0 + 8'd2, mk(wb, d0, 0), "B");
      add(0, 0, 4'b1111 & ~wb, d0 + 8'd3, mk(4'b0000, d0, 0), "B");
      add(0, 0, 4'b1111, d0 + 8'd4, mk(4'b0000, d0, 0), "B");
      add(0, 0, 4'b1111, d0 + 8'd5, mk(4'b0000, d0, 0), "B");
    end

    // C: requester 2 held past the 255-cycle timeout
    add(0, 0, 4'b0100, 8'hC0, mk(4'b0100, 8'hC0, 0), "C");
    for (int j = 1; j < 255; j++)
      add(0, 0, 4'b0100, 8'(j), mk(4'b0100, 8'hC0, 0), "C");
    add(0, 0, 4'b0100, 8'hE1, mk(4'b0000, 8'hC0, 1), "C");
    for (int j = 0; j < 6; j++)
      add(0, 0, 4'b0100, 8'hE2, mk(4'b0000, 8'hC0, 0), "C");
    add(0, 0, 4'b0000, 8'hE3, mk(4'b0000, 8'hC0, 0), "C");
    add(0, 0, 4'b0100, 8'hD5, mk(4'b0100, 8'hD5, 0), "C");
    add(0, 0, 4'b0000, 8'hE4, mk(4'b0000, 8'hD5, 0), "C");
    add(0, 0, 4'b0000, 8'hE5, mk(4'b0000, 8'hD5, 0), "C");
    add(0, 0, 4'b0000, 8'hE6, mk(4'b0000, 8'hD5, 0), "C");

    // E: HOLDOFF=0 instance, requesters 1 and 2 alternate
    add(1, 1, 4'b0000, 8'h00, mk(4'b0000, 8'h00, 0), "E");
    add(1, 0, 4'b0010, 8'hA1, mk(4'b0010, 8'hA1, 0), "E");
    add(1, 0, 4'b0100, 8'hA2, mk(4'b0000, 8'hA1, 0), "E");
    add(1, 0, 4'b0100, 8'hA3, mk(4'b0100, 8'hA3, 0), "E");
    add(1, 0, 4'b0010, 8'hA4, mk(4'b0000, 8'hA3, 0), "E");
    add(1, 0, 4'b0010, 8'hA5, mk(4'b0010, 8'hA5, 0), "E");
    add(1, 0, 4'b0000, 8'hA6, mk(4'b0000, 8'hA5, 0), "E");

    run_table();

    // D: reset asserted in the second grant cycle
    @(negedge clk);
    req_a = 4'b1000; rnd_a = 8'h77;
    @(posedge clk); #1;
    chk("D", 0, act_a(), mk(4'b1000, 8'h77, 0));
    @(negedge clk);
    rnd_a = 8'h78;
    @(posedge clk); #1;
    chk("D", 1, act_a(), mk(4'b1000, 8'h77, 0));
    @(negedge clk);
    rst_a = 1'b1;
    #1;
    chk("D", 2, act_a(), mk(4'b0000, 8'h00, 0));
    @(negedge clk);
    rst_a = 1'b0; req_a = 4'b1000; rnd_a = 8'h99;
    @(posedge clk); #1;
    chk("D", 3, act_a(), mk(4'b1000, 8'h99, 0));
    @(negedge clk);
    req_a = 4'b0000;
    @(posedge clk); #1;
    chk("D", 4, act_a(), mk(4'b0000, 8'h99, 0));

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/sc_random_arbiter.md
SC_RANDOM_ARBITER -- requirements
Module: sc_random_arbiter

Interface
REQ-001 SHALL have parameter DATAWIDTH, default 8, width of the random word.
REQ-002 SHALL have parameter NUM_REQ, default 4, number of requesters.
REQ-003 SHALL have parameter HOLDOFF, default 2, idle cycles after each release; 0 is legal.
REQ-004 SHALL have parameter TIMEOUT, default 255, maximum grant cycles before forced release.
REQ-005 SHALL have port SC_RANDOM_ARBITER_CLOCK_50, input, 1 bit: the single clock, rising edge.
REQ-006 SHALL have port SC_RANDOM_ARBITER_RESET_InHigh, input, 1 bit: asynchronous, active-high reset.
REQ-007 SHALL have port SC_RANDOM_ARBITER_rand_InBUS, input, DATAWIDTH bits: free-running LFSR word.
REQ-008 SHALL have port SC_RANDOM_ARBITER_req_InBUS, input, NUM_REQ bits: level requests, bit i = requester i.
REQ-009 SHALL have port SC_RANDOM_ARBITER_grant_OutBUS, output, NUM_REQ bits: one-hot grant, or zero.
REQ-010 SHALL have port SC_RANDOM_ARBITER_data_OutBUS, output, DATAWIDTH bits: random word latched for the current grant.
REQ-011 SHALL have port SC_RANDOM_ARBITER_valid_Out, output, 1 bit: high exactly when a grant is active.
REQ-012 SHALL have port SC_RANDOM_ARBITER_timeout_Out, output, 1 bit: one-cycle pulse on forced release.

Function
REQ-013 SHALL implement FSM states IDLE, GRANT and HOLD, all registered.
REQ-014 IDLE: if any req bit is high, SHALL select a winner, latch rand_InBUS into the data register, load the timeout counter and go to GRANT; otherwise SHALL stay in IDLE.
REQ-015 Winner selection SHALL be round-robin: search starts at last_winner+1, wrapping NUM_REQ-1 to 0.
REQ-016 Latency SHALL be 1 cycle: req seen in IDLE at edge k gives grant and valid high after edge k.
REQ-017 GRANT: grant_OutBUS SHALL be one-hot on the winner, and valid_Out SHALL be 1.
REQ-018 GRANT: data_OutBUS SHALL be stable for the whole grant, regardless of rand_InBUS.
REQ-019 GRANT: the winner deasserting its req SHALL release the grant, going to HOLD, or to IDLE when HOLDOFF=0.
REQ-020 GRANT: other requesters' req changes SHALL be ignored.
REQ-021 GRANT: a winner req held TIMEOUT cycles SHALL force release, pulse timeout_Out for 1 cycle and go to HOLD/IDLE as in REQ-019.
REQ-022 HOLD SHALL last exactly HOLDOFF cycles with grant=0 and valid=0, then go to IDLE.
REQ-023 HOLDOFF SHALL guarantee the upstream LFSR advances before the next latch, so back-to-back grants never reuse a sample.
REQ-024 After a forced release, the timed-out requester SHALL NOT be regranted until it has dropped req for at least one cycle.
REQ-025 Counters SHALL be sized to $clog2(max(HOLDOFF, TIMEOUT)+1) bits, unsigned, with no wrap-around.
REQ-026 data_OutBUS SHALL retain its last value outside GRANT.

Reset
REQ-027 Reset SHALL asynchronously force state=IDLE, grant=0, valid=0, timeout=0, data=0, counters=0 and last_winner=NUM_REQ-1, so requester 0 has first priority.
REQ-028 Reset asserted mid-grant SHALL drop grant immediately, without waiting for a clock edge.
REQ-029 The first grant after reset deassertion SHALL follow REQ-016.

Structure
REQ-030 The state encodings (IDLE=2'b00, GRANT=2'b01, HOLD=2'b10) and default parameter values SHALL live in the shared package sc_random_pkg.
REQ-031 Round-robin selection SHALL be one combinational sub-module, sc_rr_picker, taking req vector and last_winner and returning a one-hot vector plus an any flag.
REQ-032 The LFSR generator SHALL stay external and connect only through rand_InBUS.

Verification
REQ-033 Reset release, req=4'b0001, rand=8'h5A -> next cycle grant=4'b0001, valid=1, data=8'h5A; rand changes during grant -> data stays 8'h5A.
REQ-034 req=4'b1111 held, each winner drops req after 3 grant cycles, HOLDOFF=2 -> grants in order 0,1,2,3,0, separated by exactly 2 idle cycles.
REQ-035 req=4'b0100 held 255 cycles with TIMEOUT=255 -> timeout pulse 1 cycle, grant=0; requester 2 not regranted until req drops and rises again.
REQ-036 Reset asserted on the 2nd grant cycle -> grant, valid and data equal 0 immediately; after release with req=4'b1000 -> requester 3 granted.
REQ-037 HOLDOFF=0, requesters 1 and 2 alternate -> release goes to IDLE and regrant follows in the next cycle; data values differ between consecutive grants.
